// File: rtl/mul_iter_seq.sv
// rtl/mul_iter_seq.sv - iterative 32x32 multiplier (MUL/MULH/MULHSU/MULHU), BITS_PER_CYCLE bits per cycle
// Optional feature macro MUL_SIGNED_OPS_EN enables signed handling for MULH and MULHSU.
module mul_iter_seq #(
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [1:0]  i_op,
  input  logic [31:0] i_multiplicand,
  input  logic [31:0] i_multiplier,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_result
);

  localparam int N  = 32 / BITS_PER_CYCLE;
  localparam int CW = 6;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   acc_q, acc_d;
  logic [63:0]   mcand_q, mcand_d;
  logic [31:0]   mplier_q, mplier_d;
  logic [31:0]   result_q, result_d;
  logic [1:0]    op_q, op_d;

  logic [63:0]   partial;
  logic [63:0]   product;
  logic [31:0]   a_mag, b_mag;
  logic [BITS_PER_CYCLE-1:0] digit;

`ifdef MUL_SIGNED_OPS_EN
  logic neg_q, neg_d;
  logic a_neg, b_neg;

  // Magnitudes use plain 32-bit negation, so 0x80000000 maps onto itself.
  always_comb begin
    a_neg = ((i_op == 2'b01) || (i_op == 2'b10)) && i_multiplicand[31];
    b_neg = (i_op == 2'b01) && i_multiplier[31];
    a_mag = a_neg ? (~i_multiplicand + 32'd1) : i_multiplicand;
    b_mag = b_neg ? (~i_multiplier + 32'd1) : i_multiplier;
  end
`else
  always_comb begin
    a_mag = i_multiplicand;
    b_mag = i_multiplier;
  end
`endif

  assign o_ready  = (state_q == IDLE);
  assign o_valid  = (state_q == DONE);
  assign o_result = result_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    result_d = result_q;
    op_d     = op_q;
`ifdef MUL_SIGNED_OPS_EN
    neg_d    = neg_q;
`endif
    product  = '0;
    digit    = mplier_q[BITS_PER_CYCLE-1:0];
    // Partial product of the shifted multiplicand and the current multiplier digit.
    partial  = '0;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (digit[j]) begin
        partial = partial + (mcand_q << j);
      end
    end

    if (!stall) begin
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            state_d  = BUSY;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = {32'b0, a_mag};
            mplier_d = b_mag;
            op_d     = i_op;
`ifdef MUL_SIGNED_OPS_EN
            neg_d    = a_neg ^ b_neg;
`endif
          end
        end
        BUSY: begin
          acc_d    = acc_q + partial;
          mcand_d  = mcand_q << BITS_PER_CYCLE;
          mplier_d = mplier_q >> BITS_PER_CYCLE;
          cnt_d    = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_d = DONE;
`ifdef MUL_SIGNED_OPS_EN
            product = neg_q ? (~acc_d + 64'd1) : acc_d;
`else
            product = acc_d;
`endif
            // Result is latched once so it stays stable throughout DONE.
            result_d = (op_q == 2'b00) ? product[31:0] : product[63:32];
          end
        end
        DONE: begin
          if (i_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      result_q <= '0;
      op_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      result_q <= result_d;
      op_q     <= op_d;
    end
  end

`ifdef MUL_SIGNED_OPS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= neg_d;
    end
  end
`endif

endmodule

// File: doc/mul_iter_seq.md
MUL_ITER_SEQ -- requirements
Module: mul_iter_seq

Interface
- REQ-001: Parameter BITS_PER_CYCLE, default 4: multiplier bits retired per BUSY cycle; legal values are 1, 2, 4 and 8; N = 32/BITS_PER_CYCLE.
- REQ-002: clk  input  1  sole clock; all state changes on rising edge.
- REQ-003: rst  input  1  reset, asynchronous assertion, active-low (0 = reset).
- REQ-004: stall  input  1  freezes all state when 1.
- REQ-005: i_valid  input  1  request present.
- REQ-006: o_ready  output  1  block can accept a request.
- REQ-007: i_op  input  2  operation: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- REQ-008: i_multiplicand  input  32  operand rs1.
- REQ-009: i_multiplier  input  32  operand rs2.
- REQ-010: o_valid  output  1  result available.
- REQ-011: i_ready  input  1  consumer takes the result.
- REQ-012: o_result  output  32  product low word (MUL) or high word (others).

Function
- REQ-013: The block SHALL implement a three-state FSM with states IDLE, BUSY and DONE.
- REQ-014: o_ready SHALL be 1 only in IDLE; o_valid SHALL be 1 only in DONE.
- REQ-015: Acceptance SHALL occur on an edge where i_valid=1, o_ready=1 and stall=0.
- REQ-016: On acceptance, the block SHALL register the operands, op, and operand signs, load magnitudes, clear the 64-bit accumulator, and move IDLE->BUSY.
- REQ-017: Each non-stalled BUSY edge SHALL consume BITS_PER_CYCLE multiplier LSBs by shift-add into the 64-bit unsigned accumulator and increment the iteration counter.
- REQ-018: After the N-th iteration, the FSM SHALL move BUSY->DONE.
- REQ-019: o_valid SHALL rise exactly N non-stalled edges after the accepting edge (8 cycles for the default).
- REQ-020: In DONE, when the product sign is negative, the result SHALL be the two's-complement negation of the 64-bit magnitude product, applied before word select.
- REQ-021: MUL SHALL return product[31:0]; MULH, MULHSU and MULHU SHALL return product[63:32].
- REQ-022: MULH SHALL treat both operands as signed; MULHSU SHALL treat rs1 as signed and rs2 as unsigned; MULHU and MUL SHALL treat both as unsigned.
- REQ-023: The MUL low word SHALL be identical under every signedness.
- REQ-024: o_result SHALL hold stable while o_valid=1.
- REQ-025: The FSM SHALL move DONE->IDLE on an edge with i_ready=1 and stall=0.
- REQ-026: A new request SHALL NOT be accepted in the same cycle DONE is left; the minimum issue interval is N+2 cycles.
- REQ-027: When stall=1, the FSM state, counter, accumulator and o_result SHALL all hold; a stalled handshake SHALL NOT complete.
- REQ-028: Signed operand 0x80000000 SHALL produce magnitude 0x80000000 via unsigned 32-bit arithmetic, with no overflow special case.
- REQ-029: Operand changes while BUSY or DONE SHALL have no effect on the result.

Reset
- REQ-030: While rst=0, the block SHALL asynchronously force state IDLE, counter 0, accumulator 0, o_result 0, o_valid 0 and o_ready 1.
- REQ-031: Reset mid-BUSY or mid-DONE SHALL discard the operation with no o_valid pulse.
- REQ-032: The first acceptance SHALL be possible on the first edge after rst returns to 1.

Configuration
- REQ-033: With macro MUL_SIGNED_OPS_EN defined, MULH and MULHSU SHALL behave per REQ-022.
- REQ-034: Without MUL_SIGNED_OPS_EN, sign logic SHALL be omitted, i_op 01 and 10 SHALL execute as MULHU, and latency SHALL be unchanged.

Verification
- REQ-035: MUL 7 x 6, default parameter -> o_valid 8 edges after acceptance, o_result=0x0000002A.
- REQ-036: MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MUL of the same operands -> 0x00000001.
- REQ-037: Macro defined: MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF. Macro undefined: MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- REQ-038: stall=1 for 3 cycles during BUSY -> o_valid at acceptance+11 edges; result unchanged.
- REQ-039: Hold i_ready=0 for 5 cycles in DONE -> o_valid and o_result stable; IDLE one edge after i_ready=1; o_ready returns on the following cycle.
- REQ-040: rst pulsed low at BUSY iteration 4 -> o_valid=0, o_ready=1 immediately; a subsequent MUL 3 x 5 -> 0x0000000F.
